// File: rtl/serial_byte_loader.sv
`default_nettype none
// ============================================================================
// Module   : serial_byte_loader
// Function : Assembles a framed serial bit stream into a byte and drives it,
//            with a fixed-length store strobe, into a downstream byte store.
// Revision : 1.0 - initial release
// ============================================================================
module serial_byte_loader #(
  parameter int LSB_FIRST    = 1,
  parameter int STORE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       bit_in,
  input  logic       bit_valid,
  input  logic       abort,
  output logic [7:0] data,
  output logic       store,
  output logic       busy,
  output logic       done,
  output logic [7:0] byte_count
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_STORE = 2'd2
  } state_t;

  localparam logic [3:0] C_STORE_LEN = 4'(STORE_CYCLES);

  state_t     state_q,      state_d;
  logic [7:0] shift_q,      shift_d;
  logic [2:0] bit_cnt_q,    bit_cnt_d;
  logic [3:0] store_cnt_q,  store_cnt_d;
  logic [7:0] data_q,       data_d;
  logic       store_q,      store_d;
  logic       busy_q,       busy_d;
  logic       done_q,       done_d;
  logic [7:0] byte_count_q, byte_count_d;

  logic [7:0] shift_next;

  generate
    if (LSB_FIRST != 0) begin : g_lsb_first
      assign shift_next = {bit_in, shift_q[7:1]};
    end else begin : g_msb_first
      assign shift_next = {shift_q[6:0], bit_in};
    end
  endgenerate

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    store_cnt_d  = store_cnt_q;
    data_d       = data_q;
    store_d      = store_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    byte_count_d = byte_count_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_SHIFT;
          busy_d    = 1'b1;
          bit_cnt_d = 3'd0;
          shift_d   = 8'h00;
        end
      end

      ST_SHIFT: begin
        // abort wins over a coincident bit, even the 8th one
        if (abort) begin
          state_d   = ST_IDLE;
          busy_d    = 1'b0;
          bit_cnt_d = 3'd0;
          shift_d   = 8'h00;
        end else if (bit_valid) begin
          shift_d   = shift_next;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            data_d      = shift_next;
            store_d     = 1'b1;
            store_cnt_d = 4'd1;
            state_d     = ST_STORE;
          end
        end
      end

      ST_STORE: begin
        if (store_cnt_q >= C_STORE_LEN) begin
          store_d      = 1'b0;
          done_d       = 1'b1;
          byte_count_d = byte_count_q + 8'd1;
          state_d      = ST_IDLE;
          busy_d       = 1'b0;
        end else begin
          store_cnt_d = store_cnt_q + 4'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        store_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      shift_q      <= 8'h00;
      bit_cnt_q    <= 3'd0;
      store_cnt_q  <= 4'd0;
      data_q       <= 8'h00;
      store_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      byte_count_q <= 8'h00;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      store_cnt_q  <= store_cnt_d;
      data_q       <= data_d;
      store_q      <= store_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      byte_count_q <= byte_count_d;
    end
  end

  assign data       = data_q;
  assign store      = store_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign byte_count = byte_count_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_byte_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_byte_loader
// Function : Scoreboard bench for serial_byte_loader, one LSB-first and one
//            MSB-first instance sharing the same stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_byte_loader;

  localparam int STORE_CYCLES = 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       bit_in = 1'b0;
  logic       bit_valid = 1'b0;
  logic       abort = 1'b0;

  logic [7:0] data_l, cnt_l, data_m, cnt_m;
  logic       store_l, busy_l, done_l, store_m, busy_m, done_m;

  int         total = 0;
  int         bad = 0;
  logic [7:0] exp_l_q[$];
  logic [7:0] exp_m_q[$];
  logic [7:0] exp_cnt = 8'h00;

  always #5 clk = ~clk;

  serial_byte_loader #(.LSB_FIRST(1), .STORE_CYCLES(STORE_CYCLES)) u_lsb (
    .clk(clk), .reset_n(reset_n), .start(start), .bit_in(bit_in),
    .bit_valid(bit_valid), .abort(abort), .data(data_l), .store(store_l),
    .busy(busy_l), .done(done_l), .byte_count(cnt_l)
  );

  serial_byte_loader #(.LSB_FIRST(0), .STORE_CYCLES(STORE_CYCLES)) u_msb (
    .clk(clk), .reset_n(reset_n), .start(start), .bit_in(bit_in),
    .bit_valid(bit_valid), .abort(abort), .data(data_m), .store(store_m),
    .busy(busy_m), .done(done_m), .byte_count(cnt_m)
  );

  // The first bit sent lands in data[7] of the MSB-first instance
  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Sends b[0] first; returns just after the edge that samples the 8th bit
  task automatic send_bits(input logic [7:0] b, input int unsigned maxgap);
    int unsigned n;
    exp_l_q.push_back(b);
    exp_m_q.push_back(rev8(b));
    for (int i = 0; i < 8; i++) begin
      n = (maxgap == 0) ? 0 : $urandom_range(maxgap, 0);
      repeat (n) begin
        bit_valid = 1'b0;
        bit_in    = 1'($urandom_range(1, 0));
        tick();
      end
      bit_valid = 1'b1;
      bit_in    = b[i];
      tick();
    end
    bit_valid = 1'b0;
    bit_in    = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    start = 1'b1; bit_valid = 1'b1; bit_in = 1'b1; abort = 1'b0;
    tick();
    tick();
    total++;
    if (data_l !== 8'h00 || store_l !== 1'b0 || busy_l !== 1'b0 || done_l !== 1'b0 || cnt_l !== 8'h00) begin
      bad++;
      $display("FAIL reset_lsb: data=%h store=%b busy=%b done=%b cnt=%h, want all zero", data_l, store_l, busy_l, done_l, cnt_l);
    end
    total++;
    if (data_m !== 8'h00 || store_m !== 1'b0 || busy_m !== 1'b0 || done_m !== 1'b0 || cnt_m !== 8'h00) begin
      bad++;
      $display("FAIL reset_msb: data=%h store=%b busy=%b done=%b cnt=%h, want all zero", data_m, store_m, busy_m, done_m, cnt_m);
    end
    start = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
    reset_n = 1'b1;
    exp_cnt = 8'h00;
    tick();
    total++;
    if (busy_l !== 1'b0 || busy_m !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle: busy=%b/%b, want 0/0", busy_l, busy_m);
    end
  endtask

  task automatic test_frame(input string name, input logic [7:0] b, input int unsigned maxgap);
    logic [7:0] el, em;
    int         win;
    bit         stable;
    pulse_start();
    total++;
    if (busy_l !== 1'b1 || busy_m !== 1'b1) begin
      bad++;
      $display("FAIL %s_busy: busy=%b/%b, want 1/1", name, busy_l, busy_m);
    end
    send_bits(b, maxgap);
    el = exp_l_q.pop_front();
    em = exp_m_q.pop_front();
    total++;
    if (store_l !== 1'b1 || data_l !== el) begin
      bad++;
      $display("FAIL %s_lsb_data: store=%b data=%h, want store=1 data=%h", name, store_l, data_l, el);
    end
    total++;
    if (store_m !== 1'b1 || data_m !== em) begin
      bad++;
      $display("FAIL %s_msb_data: store=%b data=%h, want store=1 data=%h", name, store_m, data_m, em);
    end
    win = 0;
    stable = 1'b1;
    while (store_l === 1'b1 && win < 20) begin
      if (data_l !== el || data_m !== em || store_m !== 1'b1 || done_l !== 1'b0) stable = 1'b0;
      win++;
      tick();
    end
    exp_cnt = exp_cnt + 8'd1;
    total++;
    if (win != STORE_CYCLES || !stable) begin
      bad++;
      $display("FAIL %s_window: store high %0d cycles stable=%0d, want %0d stable=1", name, win, stable, STORE_CYCLES);
    end
    total++;
    if (done_l !== 1'b1 || done_m !== 1'b1 || cnt_l !== exp_cnt || cnt_m !== exp_cnt || busy_l !== 1'b0) begin
      bad++;
      $display("FAIL %s_done: done=%b/%b cnt=%h/%h busy=%b, want done=1/1 cnt=%h busy=0", name, done_l, done_m, cnt_l, cnt_m, busy_l, exp_cnt);
    end
    tick();
    total++;
    if (done_l !== 1'b0 || done_m !== 1'b0 || busy_l !== 1'b0 || data_l !== el || data_m !== em) begin
      bad++;
      $display("FAIL %s_after: done=%b/%b busy=%b data=%h/%h, want done=0 busy=0 data=%h/%h", name, done_l, done_m, busy_l, data_l, data_m, el, em);
    end
  endtask

  task automatic test_basic;
    test_frame("basic_a5", 8'hA5, 0);
  endtask

  task automatic test_msb_first;
    // bits 1,1,0,0,0,0,0,0 -> 0x03 LSB-first, 0xC0 MSB-first
    test_frame("order_03_c0", 8'h03, 0);
  endtask

  task automatic test_gaps;
    test_frame("gaps_3c", 8'h3C, 5);
    test_frame("gaps_rand", 8'($urandom), 5);
  endtask

  task automatic test_abort;
    bit         quiet;
    logic [7:0] cnt_before;
    test_frame("abort_pre_5a", 8'h5A, 0);
    cnt_before = exp_cnt;
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      bit_valid = 1'b1;
      bit_in    = 1'b1;
      tick();
    end
    bit_valid = 1'b0;
    tick();
    abort     = 1'b1;
    bit_valid = 1'b1;
    bit_in    = 1'b0;
    tick();
    abort     = 1'b0;
    bit_valid = 1'b0;
    total++;
    if (busy_l !== 1'b0 || busy_m !== 1'b0 || store_l !== 1'b0 || data_l !== 8'h5A || data_m !== 8'h5A) begin
      bad++;
      $display("FAIL abort_state: busy=%b/%b store=%b data=%h/%h, want busy=0 store=0 data=5a/5a", busy_l, busy_m, store_l, data_l, data_m);
    end
    // bits sent while IDLE after abort must be ignored
    quiet = 1'b1;
    for (int i = 0; i < 12; i++) begin
      bit_valid = 1'b1;
      bit_in    = 1'b1;
      tick();
      if (store_l !== 1'b0 || store_m !== 1'b0 || done_l !== 1'b0 || done_m !== 1'b0 || busy_l !== 1'b0) quiet = 1'b0;
    end
    bit_valid = 1'b0;
    total++;
    if (!quiet || cnt_l !== cnt_before || cnt_m !== cnt_before || data_l !== 8'h5A) begin
      bad++;
      $display("FAIL abort_quiet: quiet=%0d cnt=%h/%h data=%h, want quiet=1 cnt=%h data=5a", quiet, cnt_l, cnt_m, data_l, cnt_before);
    end
    test_frame("abort_post_ff", 8'hFF, 0);
  endtask

  task automatic test_reset_in_store;
    bit no_done;
    pulse_start();
    send_bits(8'h96, 0);
    void'(exp_l_q.pop_front());
    void'(exp_m_q.pop_front());
    total++;
    if (store_l !== 1'b1 || data_l !== 8'h96) begin
      bad++;
      $display("FAIL rst_store_entry: store=%b data=%h, want store=1 data=96", store_l, data_l);
    end
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    exp_cnt = 8'h00;
    total++;
    if (store_l !== 1'b0 || store_m !== 1'b0 || data_l !== 8'h00 || data_m !== 8'h00 || cnt_l !== 8'h00 || done_l !== 1'b0 || busy_l !== 1'b0) begin
      bad++;
      $display("FAIL rst_store_cut: store=%b/%b data=%h/%h cnt=%h done=%b busy=%b, want all zero", store_l, store_m, data_l, data_m, cnt_l, done_l, busy_l);
    end
    no_done = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done_l !== 1'b0 || done_m !== 1'b0 || store_l !== 1'b0) no_done = 1'b0;
    end
    total++;
    if (!no_done || cnt_l !== 8'h00 || cnt_m !== 8'h00) begin
      bad++;
      $display("FAIL rst_store_nodone: quiet=%0d cnt=%h/%h, want quiet=1 cnt=00", no_done, cnt_l, cnt_m);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] b, el, em;
    int         win;
    int         dones = 0;
    pulse_start();
    for (int f = 0; f < 256; f++) begin
      b = 8'($urandom);
      send_bits(b, 0);
      el = exp_l_q.pop_front();
      em = exp_m_q.pop_front();
      total++;
      if (store_l !== 1'b1 || data_l !== el || data_m !== em) begin
        bad++;
        $display("FAIL b2b_data[%0d]: store=%b data=%h/%h, want store=1 data=%h/%h", f, store_l, data_l, data_m, el, em);
      end
      win = 0;
      while (store_l === 1'b1 && win < 20) begin
        win++;
        tick();
      end
      exp_cnt = exp_cnt + 8'd1;
      if (done_l === 1'b1) dones++;
      total++;
      if (win != STORE_CYCLES || done_l !== 1'b1 || cnt_l !== exp_cnt || cnt_m !== exp_cnt) begin
        bad++;
        $display("FAIL b2b_window[%0d]: win=%0d done=%b cnt=%h/%h, want win=%0d done=1 cnt=%h", f, win, done_l, cnt_l, cnt_m, STORE_CYCLES, exp_cnt);
      end
      if (f < 255) pulse_start();
    end
    tick();
    total++;
    if (dones != 256 || cnt_l !== 8'h00 || cnt_m !== 8'h00 || done_l !== 1'b0 || busy_l !== 1'b0) begin
      bad++;
      $display("FAIL b2b_wrap: dones=%0d cnt=%h/%h done=%b busy=%b, want dones=256 cnt=00 done=0 busy=0", dones, cnt_l, cnt_m, done_l, busy_l);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_msb_first();
    test_gaps();
    test_abort();
    test_reset_in_store();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/serial_byte_loader.md
Name: serial_byte_loader

Overview:
Upstream stage for the 8-bit D-latch byte store. Collects a framed serial bit stream into a shift register and presents the completed byte on a stable `data` bus. Raises `store` for a fixed number of clock cycles so the downstream latches capture the byte. Also reports completion and keeps a running count of bytes delivered.

Parameters:
LSB_FIRST, 1, 1 = first received bit lands in data[0]; 0 = first received bit lands in data[7]
STORE_CYCLES, 2, number of clock cycles `store` stays high per byte (legal range 1..15)

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset_n  input  1  reset is synchronous and active-low
start  input  1  single-cycle request to begin a new frame
bit_in  input  1  serial data bit
bit_valid  input  1  bit_in is sampled on any edge where this is 1 and state is SHIFT
abort  input  1  discard the frame in progress
data  output  8  assembled byte, driven to the byte store data input
store  output  1  latch enable, driven to the byte store enable input
busy  output  1  1 whenever state != IDLE
done  output  1  one-cycle pulse after each byte's store window closes
byte_count  output  8  number of bytes delivered, modulo 256

Behaviour:
- Reset (reset_n=0 at an edge): state=IDLE; data=0x00, store=0, busy=0, done=0, byte_count=0; shift register and bit counter cleared.
- Reset overrides every other input, including mid-SHIFT or mid-STORE. If reset lands during STORE, store drops at that edge, no done pulse is issued, and the count is not incremented.
- States: IDLE, SHIFT, STORE.
- IDLE:
  - bit_valid and abort are ignored.
  - start=1 -> SHIFT, bit counter=0, shift register cleared.
- SHIFT:
  - At each edge with bit_valid=1, bit_in is shifted in and the bit counter increments.
  - Cycles with bit_valid=0 hold all state; there is no timeout.
  - LSB_FIRST=1: shift right, new bit enters at bit 7; after 8 bits the first bit is at bit 0.
  - LSB_FIRST=0: shift left, new bit enters at bit 0.
  - On the edge that samples the 8th valid bit: data <= full byte including that bit; store <= 1; state -> STORE; store-cycle counter = 1.
  - Latency: store is high in the cycle immediately following the 8th-bit edge.
  - abort=1 -> IDLE at that edge. Partial bits are discarded, data keeps its previous value, no store and no done.
  - abort has priority over bit_valid in the same cycle, so an 8th bit arriving with abort is dropped.
  - start is ignored.
- STORE:
  - store is held at 1 for exactly STORE_CYCLES cycles, with data stable throughout.
  - On the edge ending the window: store <= 0, done <= 1, byte_count <= byte_count+1 (255 wraps to 0), state -> IDLE.
  - start, abort, bit_valid are all ignored in STORE; the window always completes.
- data changes only on the SHIFT->STORE edge, never while store=1 and never on abort. The latched byte downstream therefore always matches data.
- done is high for exactly one cycle, the first IDLE cycle.
  - A start asserted during that done cycle is accepted (-> SHIFT).
  - Minimum frame-to-frame spacing is 8 + STORE_CYCLES + 1 cycles.
- busy = (state != IDLE), registered with the state.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset, then start; LSB_FIRST=1, STORE_CYCLES=2; bits 1,0,1,0,0,1,0,1 on 8 consecutive cycles -> data=0xA5 on the cycle after the 8th bit; store=1 for exactly 2 cycles; done pulse on the next cycle; byte_count=1; busy=0 after.
- LSB_FIRST=0, same bit sequence -> data=0xA5 reinterpreted MSB-first = 0xA5 (palindromic check). Then send bits 1,1,0,0,0,0,0,0 -> data=0xC0 (with LSB_FIRST=1 the same bits give 0x03).
- Bits delivered with random bit_valid gaps of 0..5 cycles; byte 0x3C -> data=0x3C; store timing measured from the 8th valid bit is unchanged; intermediate idle cycles add no bits.
- After byte 0x5A has been delivered, start a new frame, send 5 bits, then abort=1 -> IDLE; data stays 0x5A; no store, no done; byte_count unchanged. A next full frame of 0xFF delivers normally.
- reset_n=0 on the first STORE cycle -> store=0, data=0x00, byte_count=0 on the following cycle; no done pulse.
- 256 back-to-back frames, each start issued during the previous done cycle -> byte_count wraps to 0x00; each store window is exactly STORE_CYCLES cycles long; done count=256.
